// File: rtl/byte_reg_pkg.sv
// Shared types for the byte_register arbiter: command opcodes, control FSM
// states and the datapath width.
package byte_reg_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_ROR  = 2'd2,
    OP_READ = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector. With BYTE_REG_ARB_PRIORITY_EN defined,
// requester 0 overrides the rotation and leaves the pointer untouched.
module rr_arbiter #(
  parameter int  NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] id_o,
  output logic [ID_W-1:0] next_ptr_o
);

  always_comb begin
    logic [NREQ-1:0] cand;
    logic            found;
    logic [ID_W-1:0] idx;
    // NOTE: every output and local gets a value before any branch, so no
    // path through the block can leave a latch behind.
    cand       = req_i;
    found      = 1'b0;
    idx        = '0;
    grant_o    = '0;
    id_o       = '0;
    next_ptr_o = ptr_i;
`ifdef BYTE_REG_ARB_PRIORITY_EN
    cand[0] = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % NREQ);
      if (!found && cand[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = idx;
        next_ptr_o   = (int'(idx) == NREQ - 1) ? '0 : idx + ID_W'(1);
      end
    end
`ifdef BYTE_REG_ARB_PRIORITY_EN
    if (req_i[0]) begin
      grant_o    = '0;
      grant_o[0] = 1'b1;
      id_o       = '0;
      next_ptr_o = ptr_i;
    end
`endif
  end

endmodule

// File: rtl/byte_reg_arbiter.sv
// Shares one byte_register between NREQ requesters: round-robin accept, n
// strobe cycles, then a done pulse. Optional macro: BYTE_REG_ARB_PRIORITY_EN.
module byte_reg_arbiter
  import byte_reg_pkg::*;
#(
  parameter int  NREQ  = 4,
  parameter int  CNT_W = 4,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [BYTE_W*NREQ-1:0]  req_data,
  input  logic [CNT_W*NREQ-1:0]   req_count,
  output logic [NREQ-1:0]         req_ready,
  output logic                    done_valid,
  output logic [ID_W-1:0]         done_id,
  output logic [BYTE_W-1:0]       done_q,
  output logic                    reg_load,
  output logic                    reg_inc,
  output logic                    reg_rotate_right,
  output logic [BYTE_W-1:0]       reg_d,
  input  logic [BYTE_W-1:0]       reg_q
);

  logic [1:0]        op_arr   [NREQ];
  logic [BYTE_W-1:0] data_arr [NREQ];
  logic [CNT_W-1:0]  cnt_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g]   = req_op[2*g +: 2];
    assign data_arr[g] = req_data[BYTE_W*g +: BYTE_W];
    assign cnt_arr[g]  = req_count[CNT_W*g +: CNT_W];
  end

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0]   arb_grant;
  logic [ID_W-1:0]   arb_id;
  logic [ID_W-1:0]   arb_next_ptr;
  logic              accept;
  op_e               acc_op;
  logic [CNT_W-1:0]  acc_n;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req_i      (req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (arb_grant),
    .id_o       (arb_id),
    .next_ptr_o (arb_next_ptr)
  );

  // Gated by reset_n so no requester sees a grant while reset is held.
  assign req_ready = (state_q == IDLE && reset_n) ? arb_grant : '0;
  assign accept    = (state_q == IDLE) && |(req_valid & req_ready);

  always_comb begin
    acc_op = op_e'(op_arr[arb_id]);
    case (acc_op)
      OP_LOAD:        acc_n = CNT_W'(1);
      OP_INC, OP_ROR: acc_n = (cnt_arr[arb_id] == '0) ? CNT_W'(1) : cnt_arr[arb_id];
      default:        acc_n = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = acc_op;
          data_d  = data_arr[arb_id];
          cnt_d   = acc_n;
          id_d    = arb_id;
          ptr_d   = arb_next_ptr;
          state_d = (acc_n == '0) ? DONE : EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, and the
  // asynchronous reset clears every register, so an abort leaves no residue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  // Register controls come only from state and latched fields.
  always_comb begin
    reg_load         = 1'b0;
    reg_inc          = 1'b0;
    reg_rotate_right = 1'b0;
    reg_d            = '0;
    done_valid       = 1'b0;
    done_id          = '0;
    done_q           = '0;
    case (state_q)
      EXEC: begin
        case (op_q)
          OP_LOAD: begin
            reg_load = 1'b1;
            reg_d    = data_q;
          end
          OP_INC:  reg_inc          = 1'b1;
          OP_ROR:  reg_rotate_right = 1'b1;
          default: ;
        endcase
      end
      DONE: begin
        done_valid = 1'b1;
        done_id    = id_q;
        done_q     = reg_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_byte_reg_arbiter.sv
// Self-checking bench for byte_reg_arbiter: directed vectors, reset/abort
// sequences and a randomized run against a transaction-level model.
module tb_byte_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int CNT_W = 4;
  localparam int ID_W  = 2;
  localparam int LD = 0, INC = 1, ROR = 2, RD = 3;

  logic                   clk;
  logic                   reset_n;
  logic [NREQ-1:0]        req_valid;
  logic [2*NREQ-1:0]      req_op;
  logic [8*NREQ-1:0]      req_data;
  logic [CNT_W*NREQ-1:0]  req_count;
  logic [NREQ-1:0]        req_ready;
  logic                   done_valid;
  logic [ID_W-1:0]        done_id;
  logic [7:0]             done_q;
  logic                   reg_load, reg_inc, reg_rotate_right;
  logic [7:0]             reg_d;
  logic [7:0]             reg_v = 8'h00;

  byte_reg_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_op           (req_op),
    .req_data         (req_data),
    .req_count        (req_count),
    .req_ready        (req_ready),
    .done_valid       (done_valid),
    .done_id          (done_id),
    .done_q           (done_q),
    .reg_load         (reg_load),
    .reg_inc          (reg_inc),
    .reg_rotate_right (reg_rotate_right),
    .reg_d            (reg_d),
    .reg_q            (reg_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural byte_register driven by the DUT strobes.
  always @(posedge clk) begin
    if (reg_load)              reg_v <= reg_d;
    else if (reg_inc)          reg_v <= reg_v + 8'd1;
    else if (reg_rotate_right) reg_v <= {reg_v[0], reg_v[7:1]};
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-requester held command fields.
  logic [NREQ-1:0] p_val;
  logic [1:0]      p_op   [NREQ];
  logic [7:0]      p_data [NREQ];
  logic [3:0]      p_cnt  [NREQ];

  task automatic drive();
    req_valid = p_val;
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]        = p_op[i];
      req_data[8*i +: 8]      = p_data[i];
      req_count[CNT_W*i +: 4] = p_cnt[i];
    end
  endtask

  function automatic int nstrobes(int op, int cnt);
    if (op == LD) return 1;
    if (op == RD) return 0;
    return (cnt == 0) ? 1 : cnt;
  endfunction

  function automatic logic [7:0] apply(logic [7:0] v, int op, int n, logic [7:0] data);
    logic [15:0] t;
    case (op)
      LD:  return data;
      INC: return 8'(int'(v) + n);
      ROR: begin
        t = {v, v} >> (n % 8);
        return t[7:0];
      end
      default: return v;
    endcase
  endfunction

  function automatic int pick(logic [NREQ-1:0] v, int ptr);
`ifdef BYTE_REG_ARB_PRIORITY_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int i = (ptr + k) % NREQ;
`ifdef BYTE_REG_ARB_PRIORITY_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Directed command table.
  typedef struct {
    int         id;
    int         op;
    logic [7:0] data;
    int         cnt;
    int         exp_n;
    logic [7:0] exp_q;
  } vec_t;
  vec_t vecs[10];

  task automatic run_single(input int idx);
    vec_t       v;
    int         good;
    logic [3:0] oh;
    v = vecs[idx];
    oh = 4'b0001 << v.id;
    p_val = '0;
    p_val[v.id] = 1'b1;
    p_op[v.id] = 2'(v.op);
    p_data[v.id] = v.data;
    p_cnt[v.id] = 4'(v.cnt);
    drive();
    @(negedge clk);
    check($sformatf("vec%0d_accept", idx), 48'(req_ready), 48'(oh));
    @(posedge clk); #1;
    p_val = '0;
    drive();
    good = 0;
    for (int k = 0; k < v.exp_n; k++) begin
      @(negedge clk);
      if ({reg_load, reg_inc, reg_rotate_right, reg_d, done_valid} ===
          {v.op == LD, v.op == INC, v.op == ROR, (v.op == LD) ? v.data : 8'h00, 1'b0})
        good++;
      @(posedge clk); #1;
    end
    check($sformatf("vec%0d_strobe_cycles", idx), 48'(good), 48'(v.exp_n));
    @(negedge clk);
    check($sformatf("vec%0d_done", idx),
          {reg_load, reg_inc, reg_rotate_right, req_ready, done_valid, 2'(done_id), done_q},
          {3'b000, 4'b0000, 1'b1, 2'(v.id), v.exp_q});
    @(posedge clk); #1;
  endtask

  // Randomized run: expected per-cycle outputs are queued at acceptance.
  typedef struct packed {
    logic       ld, inc, ror;
    logic [7:0] d;
    logic       dv;
    logic [1:0] id;
    logic [7:0] q;
  } exp_t;
  exp_t sched[$];
  int   m_ptr;

  task automatic random_run(input int cycles, input int drain);
    exp_t       e;
    logic [3:0] exp_ready;
    int         acc, w, n, op;
    logic [7:0] fin;
    for (int cyc = 0; cyc < cycles + drain; cyc++) begin
      @(negedge clk);
      e = '0;
      exp_ready = '0;
      acc = -1;
      if (sched.size() != 0) e = sched.pop_front();
      else begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) begin
          exp_ready[w] = 1'b1;
          acc = w;
        end
      end
      check("rand_ready", 48'(req_ready), 48'(exp_ready));
      check("rand_strobe", 48'({reg_load, reg_inc, reg_rotate_right, reg_d}),
            48'({e.ld, e.inc, e.ror, e.d}));
      check("rand_done",
            48'({done_valid, done_valid ? 2'(done_id) : 2'b00, done_valid ? done_q : 8'h00}),
            48'({e.dv, e.id, e.q}));
      if (acc >= 0) begin
        op = int'(p_op[acc]);
        n = nstrobes(op, int'(p_cnt[acc]));
        fin = apply(reg_v, op, n, p_data[acc]);
        for (int k = 0; k < n; k++) begin
          e = '0;
          e.ld = (op == LD);
          e.inc = (op == INC);
          e.ror = (op == ROR);
          e.d = (op == LD) ? p_data[acc] : 8'h00;
          sched.push_back(e);
        end
        e = '0;
        e.dv = 1'b1;
        e.id = 2'(acc);
        e.q = fin;
        sched.push_back(e);
`ifdef BYTE_REG_ARB_PRIORITY_EN
        if (acc != 0) m_ptr = (acc + 1) % NREQ;
`else
        m_ptr = (acc + 1) % NREQ;
`endif
      end
      @(posedge clk); #1;
      if (acc >= 0) p_val[acc] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (cyc >= cycles) p_val[i] = 1'b0;
        else if (!p_val[i]) begin
          if ($urandom_range(2) == 0) begin
            p_val[i]  = 1'b1;
            p_op[i]   = 2'($urandom_range(3));
            p_data[i] = 8'($urandom);
            p_cnt[i]  = 4'($urandom_range(15));
          end
        end else if ($urandom_range(15) == 0) p_val[i] = 1'b0;
      end
      drive();
    end
    check("rand_drained", 48'(sched.size()), 48'(0));
  endtask

  initial begin
    int         incs;
    logic       dv_seen;
    logic [7:0] v0;
    int         eid;

    vecs[0] = '{1, LD,  8'hA5, 7,  1,  8'hA5};
    vecs[1] = '{0, LD,  8'hFE, 0,  1,  8'hFE};
    vecs[2] = '{2, INC, 8'h00, 3,  3,  8'h01};
    vecs[3] = '{3, ROR, 8'h00, 0,  1,  8'h80};
    vecs[4] = '{0, ROR, 8'h00, 4,  4,  8'h08};
    vecs[5] = '{2, RD,  8'h00, 5,  0,  8'h08};
    vecs[6] = '{3, INC, 8'h00, 0,  1,  8'h09};
    vecs[7] = '{1, INC, 8'h00, 15, 15, 8'h18};
    vecs[8] = '{0, LD,  8'h81, 2,  1,  8'h81};
    vecs[9] = '{2, ROR, 8'h00, 9,  9,  8'hC0};

    // Reset with every requester asking for READ.
    reset_n = 1'b0;
    p_val = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      p_op[i] = 2'(RD);
      p_data[i] = 8'h00;
      p_cnt[i] = 4'h0;
    end
    drive();
    #12;
    check("reset_outputs",
          48'({req_ready, reg_load, reg_inc, reg_rotate_right, reg_d, done_valid, 2'(done_id), done_q}),
          48'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Continuous READ from all four: accept/done alternate.
    for (int k = 0; k < 10; k++) begin
`ifdef BYTE_REG_ARB_PRIORITY_EN
      eid = 0;
`else
      eid = (k / 2) % NREQ;
`endif
      @(negedge clk);
      if (k % 2 == 0)
        check($sformatf("rr_accept%0d", k / 2),
              48'({req_ready, done_valid, reg_load, reg_inc, reg_rotate_right}),
              48'({4'b0001 << eid, 4'b0000}));
      else
        check($sformatf("rr_done%0d", k / 2),
              48'({req_ready, done_valid, 2'(done_id), reg_load, reg_inc, reg_rotate_right}),
              48'({4'b0000, 1'b1, 2'(eid), 3'b000}));
      @(posedge clk); #1;
    end
    p_val = '0;
    drive();

    for (int i = 0; i < 10; i++) run_single(i);

    // Abort a long INC with reset after two strobes.
    v0 = reg_v;
    p_val = 4'b0001;
    p_op[0] = 2'(INC);
    p_cnt[0] = 4'd8;
    drive();
    @(negedge clk);
    @(posedge clk); #1;
    p_val = '0;
    drive();
    incs = 0;
    repeat (2) begin
      @(negedge clk);
      if (reg_inc) incs++;
      @(posedge clk);
    end
    #1;
    reset_n = 1'b0;
    p_val = 4'b0010;
    p_op[1] = 2'(LD);
    p_data[1] = 8'h3C;
    drive();
    #1;
    check("abort_outputs",
          48'({reg_load, reg_inc, reg_rotate_right, reg_d, done_valid, req_ready}), 48'(0));
    check("abort_inc_cycles", 48'(incs), 48'(2));
    dv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      dv_seen |= done_valid;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    dv_seen |= done_valid;
    check("abort_regval", 48'(reg_v), 48'(8'(v0 + 8'd2)));
    check("grant_after_abort", 48'(req_ready), 48'(4'b0010));
    @(posedge clk); #1;
    p_val = '0;
    drive();
    @(negedge clk);
    dv_seen |= done_valid;
    check("abort_no_done", 48'(dv_seen), 48'(0));
    check("abort_next_load", 48'({reg_load, reg_d}), 48'({1'b1, 8'h3C}));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_next_done", 48'({done_valid, 2'(done_id), done_q}), 48'({1'b1, 2'd1, 8'h3C}));
    @(posedge clk); #1;

    // Fresh reset so the model pointer starts at 0.
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_ptr = 0;
    sched.delete();
    random_run(1500, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
